// File: rtl/mem_bridge_pkg.sv
// mem_bridge_pkg: shared types and constants for the CPU-to-memory bridge.
//   state_t         - bridge FSM state encoding
//   TIMEOUT_DEFAULT - default maximum wait cycles per bus phase
//   is_bus()        - true for states that drive a memory request
package mem_bridge_pkg;

    localparam int unsigned ADDR_W          = 20;
    localparam int unsigned DATA_W          = 16;
    localparam int unsigned INSTR_W         = 32;
    localparam int unsigned TIMEOUT_DEFAULT = 255;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        I_LO = 3'd3,
        I_HI = 3'd4,
        DONE = 3'd5
    } state_t;

    function automatic logic is_bus(input state_t s);
        return (s == WR) || (s == RD) || (s == I_LO) || (s == I_HI);
    endfunction

endpackage

// File: rtl/mem_bridge_phase_timer.sv
// phase_timer: counts wait cycles of one memory bus phase.
//   clk, rst - rising-edge clock, synchronous active-high reset
//   clear    - restart the count (used between phases)
//   enable   - a bus phase is in progress
//   expired  - high in the TIMEOUT-th cycle of an enabled phase
module phase_timer
    import mem_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // Count holds at LAST; the owner advances the phase in that cycle.
    assign expired = enable && (count == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/mem_bridge.sv
// mem_bridge: turns level CPU read/write/fetch requests into req/ack memory
// phases. A fetch is two 16-bit reads (addr, addr+1) assembled into 32 bits.
// Each phase aborts after TIMEOUT cycles with data 16'hFFFF and sets c_err.
//   CPU side : c_addr, c_wdata, c_read, c_write, c_instr, c_read_done (in)
//              c_rdata, c_instr_out, c_busy, c_cack, c_ready, c_err (out)
//   Mem side : m_addr, m_wdata, m_req, m_we (out); m_rdata, m_ack (in)
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  c_addr,
    input  logic [DATA_W-1:0]  c_wdata,
    input  logic               c_read,
    input  logic               c_write,
    input  logic               c_instr,
    input  logic               c_read_done,
    output logic [DATA_W-1:0]  c_rdata,
    output logic [INSTR_W-1:0] c_instr_out,
    output logic               c_busy,
    output logic               c_cack,
    output logic               c_ready,
    output logic               c_err,
    output logic [ADDR_W-1:0]  m_addr,
    output logic [DATA_W-1:0]  m_wdata,
    output logic               m_req,
    output logic               m_we,
    input  logic [DATA_W-1:0]  m_rdata,
    input  logic               m_ack
);

    state_t state, state_n;

    logic              bus_c;
    logic              ack_c;
    logic              expired;
    logic              timeout_c;
    logic              step_c;
    logic              accept_c;
    logic              clear_c;
    logic [DATA_W-1:0] phase_data_c;

    // Phase bookkeeping; m_ack only counts while a request is out.
    assign bus_c        = is_bus(state);
    assign ack_c        = m_req && m_ack;
    assign timeout_c    = expired && !ack_c;
    assign step_c       = bus_c && (ack_c || expired);
    assign clear_c      = !bus_c || step_c;
    assign phase_data_c = ack_c ? m_rdata : DATA_W'(16'hFFFF);

    phase_timer #(.TIMEOUT(TIMEOUT)) u_phase_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear_c),
        .enable  (bus_c),
        .expired (expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state; write wins over read, and DONE exit never overlaps acceptance.
    always_comb begin
        state_n  = state;
        accept_c = 1'b0;
        case (state)
            IDLE: begin
                if (c_write) begin
                    state_n  = WR;
                    accept_c = 1'b1;
                end else if (c_read) begin
                    state_n  = c_instr ? I_LO : RD;
                    accept_c = 1'b1;
                end
            end
            WR, RD, I_HI: begin
                if (step_c) state_n = DONE;
            end
            I_LO: begin
                if (step_c) state_n = I_HI;
            end
            DONE: begin
                if ((c_read && c_read_done) || (!c_read && !c_write)) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Registered outputs and datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_rdata     <= '0;
            c_instr_out <= '0;
            c_busy      <= 1'b0;
            c_cack      <= 1'b0;
            c_ready     <= 1'b0;
            c_err       <= 1'b0;
            m_addr      <= '0;
            m_wdata     <= '0;
            m_req       <= 1'b0;
            m_we        <= 1'b0;
        end else begin
            c_cack  <= accept_c;
            c_busy  <= is_bus(state_n);
            m_req   <= is_bus(state_n);
            m_we    <= (state_n == WR);
            c_ready <= (state_n == DONE);

            if (accept_c) begin
                m_addr  <= c_addr;
                m_wdata <= c_wdata;
                c_err   <= 1'b0;
            end

            if (step_c) begin
                if (timeout_c) c_err <= 1'b1;
                case (state)
                    RD:   c_rdata <= phase_data_c;
                    I_LO: begin
                        c_instr_out[15:0] <= phase_data_c;
                        // m_addr still holds the latched address; wraps at 20 bits.
                        m_addr            <= m_addr + ADDR_W'(1);
                    end
                    I_HI: c_instr_out[31:16] <= phase_data_c;
                    default: ;
                endcase
            end
        end
    end

endmodule
